// File: rtl/sdram_aref_if.sv
// Handshake and command bus between the auto-refresh generator and its arbiter/init logic.
// The slave modport is the refresh generator; the master modport drives init_done and grants.
interface sdram_aref_if;
   logic        init_done;
   logic        ref_en;
   logic        ref_req;
   logic [3:0]  aref_cmd;
   logic [11:0] aref_addr;
   logic        ref_busy;
   logic        ref_end;
   logic        ref_overrun;

   modport master (
      output init_done, ref_en,
      input  ref_req, aref_cmd, aref_addr, ref_busy, ref_end, ref_overrun
   );

   modport slave (
      input  init_done, ref_en,
      output ref_req, aref_cmd, aref_addr, ref_busy, ref_end, ref_overrun
   );
endinterface

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh generator: counts refresh intervals after init, requests the bus,
// and on grant issues PRECHARGE-ALL then AUTO-REFRESH, pulsing ref_end when the bus is released.
module sdram_aref #(
   parameter int REF_PERIOD = 750,
   parameter int TRP_CYC    = 2,
   parameter int TRFC_CYC   = 4
) (
   input logic         sclk,
   input logic         rst,
   sdram_aref_if.slave bus
);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PREC = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   localparam int CNT_W    = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
   localparam int WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      TRP  = 3'd2,
      AREF = 3'd3,
      TRFC = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_next;
   logic [CNT_W-1:0]  period_cnt;
   logic [1:0]        debt;

   logic              tick;
   logic              grant;
   logic              fin;
   logic [3:0]        cmd_next;
   logic [11:0]       addr_next;

   assign tick = bus.init_done && (period_cnt == CNT_W'(REF_PERIOD - 1));

   // Next-state and next-output decode; outputs are registered from the state being entered.
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      grant      = 1'b0;
      fin        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.ref_req && bus.ref_en) begin
               grant      = 1'b1;
               state_next = PRE;
            end
         end
         PRE: begin
            state_next = TRP;
            wait_next  = WAIT_W'(TRP_CYC - 1);
         end
         TRP: begin
            if (wait_cnt == '0) state_next = AREF;
            else                wait_next  = wait_cnt - WAIT_W'(1);
         end
         AREF: begin
            state_next = TRFC;
            wait_next  = WAIT_W'(TRFC_CYC - 1);
         end
         TRFC: begin
            if (wait_cnt == '0) begin
               state_next = DONE;
               fin        = 1'b1;
            end else begin
               wait_next  = wait_cnt - WAIT_W'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      cmd_next  = CMD_NOP;
      addr_next = 12'h000;
      if (state_next == PRE) begin
         cmd_next  = CMD_PREC;
         addr_next = 12'h400;
      end else if (state_next == AREF) begin
         cmd_next  = CMD_AREF;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   // The interval counter free-runs once init is done; servicing never re-phases it.
   always_ff @(posedge sclk) begin
      if (rst || !bus.init_done || tick) period_cnt <= '0;
      else                               period_cnt <= period_cnt + CNT_W'(1);
   end

   // Refresh debt: a tick and a completion on the same edge cancel out.
   always_ff @(posedge sclk) begin
      if (rst) begin
         debt            <= 2'd0;
         bus.ref_overrun <= 1'b0;
      end else if (!bus.init_done) begin
         debt            <= 2'd0;
      end else if (tick && !fin) begin
         if (debt == 2'd3) bus.ref_overrun <= 1'b1;
         else              debt            <= debt + 2'd1;
      end else if (fin && !tick && debt != 2'd0) begin
         debt            <= debt - 2'd1;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         bus.ref_req   <= 1'b0;
         bus.aref_cmd  <= CMD_NOP;
         bus.aref_addr <= 12'h000;
         bus.ref_busy  <= 1'b0;
         bus.ref_end   <= 1'b0;
      end else begin
         bus.ref_req   <= (state == IDLE) && (debt != 2'd0) && !grant;
         bus.aref_cmd  <= cmd_next;
         bus.aref_addr <= addr_next;
         bus.ref_busy  <= (state_next != IDLE);
         bus.ref_end   <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_sdram_aref.sv
// Self-checking bench for sdram_aref: directed scenarios plus random traffic, every cycle
// compared against a position-in-sequence reference model built from the refresh rules.
module tb_sdram_aref;

   localparam int REF_PERIOD = 10;
   localparam int TRP_CYC    = 2;
   localparam int TRFC_CYC   = 4;
   localparam int SEQ_LEN    = TRP_CYC + TRFC_CYC + 3;
   localparam int AREF_POS   = TRP_CYC + 2;

   logic sclk;
   logic rst;

   sdram_aref_if bus ();

   sdram_aref #(
      .REF_PERIOD (REF_PERIOD),
      .TRP_CYC    (TRP_CYC),
      .TRFC_CYC   (TRFC_CYC)
   ) dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   initial sclk = 1'b0;
   always #10 sclk = ~sclk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: phase within the refresh period, outstanding refreshes, and the
   // position 1..SEQ_LEN inside a granted sequence (0 when no sequence owns the bus).
   int m_phase = 0;
   int m_debt  = 0;
   int m_pos   = 0;
   bit m_req   = 1'b0;
   bit m_over  = 1'b0;

   task automatic modelEdge(input bit r, input bit ini, input bit en);
      int d;
      bit tick, fin, grant, req_n;
      if (r) begin
         m_phase = 0;
         m_debt  = 0;
         m_pos   = 0;
         m_req   = 1'b0;
         m_over  = 1'b0;
         return;
      end
      tick  = ini && (m_phase == REF_PERIOD - 1);
      grant = (m_pos == 0) && m_req && en;
      fin   = (m_pos == SEQ_LEN - 1);
      req_n = (m_pos == 0) && (m_debt != 0) && !grant;
      m_phase = ini ? (m_phase + 1) % REF_PERIOD : 0;
      d = m_debt + int'(tick) - int'(fin);
      if (d > 3) begin
         d      = 3;
         m_over = 1'b1;
      end
      if (d < 0) d = 0;
      m_debt = ini ? d : 0;
      if (grant)                m_pos = 1;
      else if (m_pos == SEQ_LEN) m_pos = 0;
      else if (m_pos != 0)       m_pos = m_pos + 1;
      m_req = req_n;
   endtask

   task automatic chk(input string tag, input logic [11:0] observed, input logic [11:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
      end
   endtask

   task automatic checkOutput();
      logic [3:0]  exp_cmd;
      logic [11:0] exp_addr;
      exp_cmd  = (m_pos == 1) ? 4'b0010 : (m_pos == AREF_POS) ? 4'b0001 : 4'b0111;
      exp_addr = (m_pos == 1) ? 12'h400 : 12'h000;
      chk("ref_req",     {11'd0, bus.ref_req},     {11'd0, m_req});
      chk("aref_cmd",    {8'd0, bus.aref_cmd},     {8'd0, exp_cmd});
      chk("aref_addr",   bus.aref_addr,            exp_addr);
      chk("ref_busy",    {11'd0, bus.ref_busy},    {11'd0, (m_pos != 0)});
      chk("ref_end",     {11'd0, bus.ref_end},     {11'd0, (m_pos == SEQ_LEN)});
      chk("ref_overrun", {11'd0, bus.ref_overrun}, {11'd0, m_over});
   endtask

   task automatic applyStimulus(input bit r, input bit ini, input bit en);
      rst           = r;
      bus.init_done = ini;
      bus.ref_en    = en;
      @(posedge sclk);
      modelEdge(r, ini, en);
      #1;
      checkOutput();
   endtask

   initial begin
      int guard;
      rst           = 1'b1;
      bus.init_done = 1'b0;
      bus.ref_en    = 1'b0;

      // Reset, then a long stretch with init still in progress: nothing may happen.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("idle_cmd_no_init", {8'd0, bus.aref_cmd}, 12'h007);

      // First tick on the 10th edge after init; request one edge later and held.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      chk("req_low_at_tick", {11'd0, bus.ref_req}, 12'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      chk("req_high_after_tick", {11'd0, bus.ref_req}, 12'd1);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

      // Single-cycle grant runs one complete PREC / AREF sequence.
      applyStimulus(1'b0, 1'b1, 1'b1);
      chk("prec_after_grant", {bus.aref_cmd, bus.aref_addr[11:4]}, {4'b0010, 8'h40});
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0);

      // Debt saturates and overruns, then continuous grants drain it back to back.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 45; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      chk("overrun_set", {11'd0, bus.ref_overrun}, 12'd1);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1);

      // Continuous grant from a fresh start lines ref_end up with a period tick.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b1);

      // Reset landing in the AREF cycle aborts the sequence immediately.
      guard = 0;
      while (m_pos != AREF_POS && guard < 40) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("aref_before_abort", {8'd0, bus.aref_cmd}, 12'h001);
      applyStimulus(1'b1, 1'b1, 1'b0);
      chk("abort_busy_low", {11'd0, bus.ref_busy}, 12'd0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0);

      // Random traffic, including rare init drops and resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 39) != 0),
                       ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
